// File: rtl/jpeg_pkg.sv
// Shared types and defaults for the JPEG pipe sequencer and datapath.
// Optional feature macro: JPEG_PIPE_QSEL_EN (luma/chroma quant table select).
package jpeg_pkg;

  localparam int ADDR_W_DEF       = 6;
  localparam int BLK_SIZE         = 2 ** ADDR_W_DEF;
  localparam int QUANT_OFFSET_DEF = 47;
  localparam int STARTUP_DLY_DEF  = 4;
  localparam int ZZ_DELAY_DEF     = 106;
  localparam int BLK_CNT_W_DEF    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/jpeg_pipe_sequencer_if.sv
// Host/datapath bundle of the JPEG pipe sequencer.
// Optional feature macro: JPEG_PIPE_QSEL_EN adds i_qtab_sel and widens o_addr_quant.
interface jpeg_pipe_sequencer_if #(
  parameter int ADDR_W    = 6,
  parameter int BLK_CNT_W = 16
);

`ifdef JPEG_PIPE_QSEL_EN
  localparam int QA_W = ADDR_W + 1;
  logic                 i_qtab_sel;
`else
  localparam int QA_W = ADDR_W;
`endif

  logic                 i_start;
  logic [BLK_CNT_W-1:0] i_num_blocks;
  logic                 i_stall;
  logic                 o_pipe_rst;
  logic                 o_ce;
  logic                 o_ce_zig_zag;
  logic [ADDR_W-1:0]    o_addr_input;
  logic [QA_W-1:0]      o_addr_quant;
  logic [BLK_CNT_W-1:0] o_block_idx;
  logic                 o_busy;
  logic                 o_done;

`ifdef JPEG_PIPE_QSEL_EN
  modport master (
    output i_start, i_num_blocks, i_stall, i_qtab_sel,
    input  o_pipe_rst, o_ce, o_ce_zig_zag, o_addr_input,
    input  o_addr_quant, o_block_idx, o_busy, o_done
  );
  modport slave (
    input  i_start, i_num_blocks, i_stall, i_qtab_sel,
    output o_pipe_rst, o_ce, o_ce_zig_zag, o_addr_input,
    output o_addr_quant, o_block_idx, o_busy, o_done
  );
`else
  modport master (
    output i_start, i_num_blocks, i_stall,
    input  o_pipe_rst, o_ce, o_ce_zig_zag, o_addr_input,
    input  o_addr_quant, o_block_idx, o_busy, o_done
  );
  modport slave (
    input  i_start, i_num_blocks, i_stall,
    output o_pipe_rst, o_ce, o_ce_zig_zag, o_addr_input,
    output o_addr_quant, o_block_idx, o_busy, o_done
  );
`endif

endinterface

// File: rtl/jpeg_addr_gen.sv
// Wrapping input/quant address counter pair; quant leads input by QUANT_OFFSET.
// o_wrap flags the enabled step from the last address back to zero.
module jpeg_addr_gen
  import jpeg_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int QUANT_OFFSET = QUANT_OFFSET_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr_input,
  output logic [ADDR_W-1:0] o_addr_quant,
  output logic              o_wrap
);

  localparam logic [ADDR_W-1:0] QOFS = ADDR_W'(QUANT_OFFSET);

  logic [ADDR_W-1:0] r_ai;
  logic [ADDR_W-1:0] r_aq;

  // Both counters step together; clear restores the idle values.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ai <= '0;
      r_aq <= QOFS;
    end else if (i_en) begin
      r_ai <= r_ai + ADDR_W'(1);
      r_aq <= r_aq + ADDR_W'(1);
    end
  end

  assign o_addr_input = r_ai;
  assign o_addr_quant = r_aq;
  assign o_wrap       = i_en && (r_ai == '1);

endmodule

// File: rtl/jpeg_pipe_sequencer.sv
// Job sequencer for the 8x8 JPEG datapath: prime, run, drain, done.
// Optional feature macro: JPEG_PIPE_QSEL_EN (quant table select as addr MSB).
module jpeg_pipe_sequencer
  import jpeg_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int QUANT_OFFSET = QUANT_OFFSET_DEF,
  parameter int STARTUP_DLY  = STARTUP_DLY_DEF,
  parameter int ZZ_DELAY     = ZZ_DELAY_DEF,
  parameter int BLK_CNT_W    = BLK_CNT_W_DEF
) (
  input logic                  i_clk,
  input logic                  i_rst,
  jpeg_pipe_sequencer_if.slave bus
);

  localparam int CW = BLK_CNT_W + ADDR_W + 1;
  localparam int PW = (STARTUP_DLY > 1) ? $clog2(STARTUP_DLY) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(STARTUP_DLY - 1);
  localparam logic [CW-1:0] ZZ     = CW'(ZZ_DELAY);

  state_t               r_state;
  state_t               w_next;
  logic [PW-1:0]        r_prime_cnt;
  logic [BLK_CNT_W-1:0] r_nblk;
  logic [BLK_CNT_W-1:0] r_blk_idx;
  logic [CW-1:0]        r_ce_cnt;
  logic [CW-1:0]        w_total;
  logic                 w_ce;
  logic                 w_wrap;
  logic                 w_last_blk;
  logic                 w_ce_last;
  logic                 w_accept;
  logic                 w_clr;
  logic                 w_pipe_rst;
  logic                 w_done;
  logic                 w_busy;
  logic [ADDR_W-1:0]    w_ai;
  logic [ADDR_W-1:0]    w_aq;
`ifdef JPEG_PIPE_QSEL_EN
  logic                 r_qsel;
`endif

  assign w_accept   = (r_state == S_IDLE) && bus.i_start;
  assign w_ce       = ((r_state == S_RUN) || (r_state == S_DRAIN))
                      && !bus.i_stall;
  assign w_clr      = (r_state == S_DONE);
  assign w_last_blk = (r_blk_idx == r_nblk - BLK_CNT_W'(1));
  assign w_total    = (CW'(r_nblk) << ADDR_W) + ZZ;
  assign w_ce_last  = w_ce && (r_ce_cnt == w_total - CW'(1));

  jpeg_addr_gen #(
    .ADDR_W       (ADDR_W),
    .QUANT_OFFSET (QUANT_OFFSET)
  ) u_addr (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_clr),
    .i_en         (w_ce),
    .o_addr_input (w_ai),
    .o_addr_quant (w_aq),
    .o_wrap       (w_wrap)
  );

  // State register plus block, prime and ce-cycle counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_prime_cnt <= '0;
      r_nblk      <= '0;
      r_blk_idx   <= '0;
      r_ce_cnt    <= '0;
`ifdef JPEG_PIPE_QSEL_EN
      r_qsel      <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_prime_cnt <= (r_state == S_PRIME) ? r_prime_cnt + PW'(1) : '0;
      if (w_accept) begin
        r_nblk <= bus.i_num_blocks;
`ifdef JPEG_PIPE_QSEL_EN
        r_qsel <= bus.i_qtab_sel;
`endif
      end
      if (w_clr) begin
        r_blk_idx <= '0;
        r_ce_cnt  <= '0;
`ifdef JPEG_PIPE_QSEL_EN
        r_qsel    <= 1'b0;
`endif
      end else begin
        if ((r_state == S_RUN) && w_wrap && !w_last_blk)
          r_blk_idx <= r_blk_idx + BLK_CNT_W'(1);
        if (w_ce && (r_ce_cnt != '1))
          r_ce_cnt <= r_ce_cnt + CW'(1);
      end
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    w_next     = r_state;
    w_pipe_rst = 1'b0;
    w_done     = 1'b0;
    w_busy     = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.i_start)
          w_next = (bus.i_num_blocks != '0) ? S_PRIME : S_DONE;
      end
      S_PRIME: begin
        w_pipe_rst = (r_prime_cnt == '0);
        if (r_prime_cnt == P_LAST)
          w_next = S_RUN;
      end
      S_RUN: begin
        if (w_ce_last)
          w_next = S_DONE;
        else if (w_wrap && w_last_blk)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_ce_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.o_pipe_rst   = w_pipe_rst;
  assign bus.o_ce         = w_ce;
  assign bus.o_ce_zig_zag = w_ce && (r_ce_cnt >= ZZ);
  assign bus.o_addr_input = w_ai;
  assign bus.o_block_idx  = r_blk_idx;
  assign bus.o_busy       = w_busy;
  assign bus.o_done       = w_done;
`ifdef JPEG_PIPE_QSEL_EN
  assign bus.o_addr_quant = {r_qsel, w_aq};
`else
  assign bus.o_addr_quant = w_aq;
`endif

endmodule

// File: tb/tb_jpeg_pipe_sequencer.sv
// Scoreboard bench for jpeg_pipe_sequencer.
// Optional feature macro: JPEG_PIPE_QSEL_EN enables the table-select job.
module tb_jpeg_pipe_sequencer;

  typedef struct {
    int cyc;
    int ai;
    int aq;
    int blk;
    int zz;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  rec_t ce_q[$];
  int   pr_q[$];
  int   done_q[$];

  jpeg_pipe_sequencer_if #(.ADDR_W(6), .BLK_CNT_W(16)) bus ();

  jpeg_pipe_sequencer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every ce, pipe_rst and done is matched against the queues.
  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      if (bus.o_ce) begin
        if (ce_q.size() == 0) begin
          chk("ce_unexpected", int'(bus.o_ce), 0);
        end else begin
          r = ce_q.pop_front();
          chk("ce_cycle", cyc, r.cyc);
          chk("addr_input", int'(bus.o_addr_input), r.ai);
          chk("addr_quant", int'(bus.o_addr_quant), r.aq);
          chk("block_idx", int'(bus.o_block_idx), r.blk);
          chk("ce_zig_zag", int'(bus.o_ce_zig_zag), r.zz);
        end
      end
      if (bus.o_ce_zig_zag)
        chk("zz_needs_ce", int'(bus.o_ce), 1);
      if (bus.o_pipe_rst) begin
        if (pr_q.size() == 0)
          chk("pipe_rst_unexpected", int'(bus.o_pipe_rst), 0);
        else
          chk("pipe_rst_cycle", cyc, pr_q.pop_front());
      end
      if (bus.o_done) begin
        if (done_q.size() == 0)
          chk("done_unexpected", int'(bus.o_done), 0);
        else
          chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a job and push its expected ce stream, pipe_rst and done.
  task automatic issue(input int nb, input int sp, input int sl,
                       input bit qs, output int k);
    int c;
    int d;
    rec_t r;
    @(posedge clk);
    #1;
    k = cyc;
    bus.i_start = 1'b1;
    bus.i_num_blocks = nb[15:0];
`ifdef JPEG_PIPE_QSEL_EN
    bus.i_qtab_sel = qs;
`endif
    if (nb == 0) begin
      done_q.push_back(k + 1);
    end else begin
      pr_q.push_back(k + 1);
      c = nb * 64 + 106;
      for (int i = 0; i < c; i++) begin
        d = (sp >= 0 && i >= sp) ? sl : 0;
        r.cyc = k + 5 + i + d;
        r.ai  = i % 64;
        r.aq  = ((47 + i) % 64) + (qs ? 64 : 0);
        r.blk = (i / 64 < nb) ? i / 64 : nb - 1;
        r.zz  = (i >= 106) ? 1 : 0;
        ce_q.push_back(r);
      end
      done_q.push_back(k + 5 + c + ((sp >= 0) ? sl : 0));
    end
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_done && n < bound);
    chk("done_seen", int'(bus.o_done), 1);
    @(negedge clk);
    chk("busy_after_done", int'(bus.o_busy), 0);
    chk("ai_after_done", int'(bus.o_addr_input), 0);
    chk("aq_after_done", int'(bus.o_addr_quant), 47);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(bus.o_busy), 0);
    chk({tag, "_ce"}, int'(bus.o_ce), 0);
    chk({tag, "_zz"}, int'(bus.o_ce_zig_zag), 0);
    chk({tag, "_pipe_rst"}, int'(bus.o_pipe_rst), 0);
    chk({tag, "_done"}, int'(bus.o_done), 0);
    chk({tag, "_ai"}, int'(bus.o_addr_input), 0);
    chk({tag, "_aq"}, int'(bus.o_addr_quant), 47);
    chk({tag, "_blk"}, int'(bus.o_block_idx), 0);
  endtask

  initial begin
    int k;
    bus.i_start = 1'b0;
    bus.i_num_blocks = '0;
    bus.i_stall = 1'b0;
`ifdef JPEG_PIPE_QSEL_EN
    bus.i_qtab_sel = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    // One block, no stall.
    issue(1, -1, 0, 1'b0, k);
    wait_done(400);

    // Three blocks, with a start pulse during RUN that must be ignored.
    issue(3, -1, 0, 1'b0, k);
    wait_until(k + 40);
    bus.i_start = 1'b1;
    bus.i_num_blocks = 16'd7;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done(800);

    // Ten-cycle stall at addr_input = 20.
    issue(1, 20, 10, 1'b0, k);
    wait_until(k + 25);
    bus.i_stall = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_ce", int'(bus.o_ce), 0);
      chk("stall_zz", int'(bus.o_ce_zig_zag), 0);
      chk("stall_ai", int'(bus.o_addr_input), 20);
      chk("stall_aq", int'(bus.o_addr_quant), 3);
      @(posedge clk);
      #1;
    end
    bus.i_stall = 1'b0;
    wait_done(400);

    // Zero-block job: immediate done, no pipe_rst, no ce.
    issue(0, -1, 0, 1'b0, k);
    wait_done(10);

    // Reset in DRAIN aborts the job without done.
    issue(1, -1, 0, 1'b0, k);
    wait_until(k + 79);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce_q.delete();
    done_q.delete();
    @(negedge clk);
    chk_reset_vals("abort");
    repeat (150) @(negedge clk);
    chk("abort_idle", int'(bus.o_busy), 0);

`ifdef JPEG_PIPE_QSEL_EN
    // Chroma table: quant MSB high for the whole job.
    issue(2, -1, 0, 1'b1, k);
    @(negedge clk);
    wait_until(k + 5);
    @(negedge clk);
    chk("qsel_first_aq", int'(bus.o_addr_quant), 111);
    wait_done(600);
`endif

    repeat (5) @(negedge clk);
    chk("ce_q_empty", ce_q.size(), 0);
    chk("pr_q_empty", pr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
